// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and defaults for the memory responder.
//   resp_state_t : responder FSM states (IDLE, WAIT, DONE, RELEASE)
//   resp_op_t    : captured operation (read or write)
//   MEM_*_DEFAULT: default word width, index width and access latency
package mem_responder_pkg;

  localparam int MEM_SIZE_WORD_DEFAULT = 16;
  localparam int MEM_ADDR_BITS_DEFAULT = 8;
  localparam int MEM_LATENCY_DEFAULT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } resp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } resp_op_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU <-> memory request/response handshake.
//   readM, writeM : level requests from the CPU, held until ready_m
//   address       : word address from the CPU
//   ready_m       : one-cycle completion pulse from the memory
//   err_m         : one-cycle protocol/range error pulse from the memory
// The shared tri-state data bus is carried as a direct inout port of the
// responder so the resolved net lives in the enclosing wrapper.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int SIZE_WORD = MEM_SIZE_WORD_DEFAULT
) ();

  logic                 readM;
  logic                 writeM;
  logic [SIZE_WORD-1:0] address;
  logic                 ready_m;
  logic                 err_m;

  modport master (
    output readM, writeM, address,
    input  ready_m, err_m
  );

  modport slave (
    input  readM, writeM, address,
    output ready_m, err_m
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_responder_mem_array: word storage for the responder.
//   clk                              : rising-edge clock
//   cpu_we, cpu_addr, cpu_wdata      : CPU write port (higher priority)
//   load_we, load_addr, load_wdata   : boot/bench load write port
//   rd_en, rd_addr, rd_data          : registered read port (read-first)
// Contents are never reset.
module mem_responder_mem_array
  import mem_responder_pkg::*;
#(
  parameter int WIDTH     = MEM_SIZE_WORD_DEFAULT,
  parameter int ADDR_BITS = MEM_ADDR_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  input  logic                 load_we,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WIDTH-1:0]     load_wdata,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic             load_blocked;

  // A load colliding with a CPU write on the same index is dropped so the
  // CPU value lands.
  assign load_blocked = cpu_we && (cpu_addr == load_addr);

  always_ff @(posedge clk) begin
    if (cpu_we) begin
      mem_q[cpu_addr] <= cpu_wdata;
    end
    if (load_we && !load_blocked) begin
      mem_q[load_addr] <= load_wdata;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-word memory responder.
//   clk, reset_n   : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : readM/writeM/address in, ready_m/err_m out
//   data           : shared bus; sampled at write capture, driven with read
//                    data while the read request is held after completion
//   load_*         : load-port write, honoured in every state
//   access_count   : completed CPU accesses, wrapping
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int SIZE_WORD = MEM_SIZE_WORD_DEFAULT,
  parameter int ADDR_BITS = MEM_ADDR_BITS_DEFAULT,
  parameter int LATENCY   = MEM_LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_responder_if.slave       bus,
  inout  wire  [SIZE_WORD-1:0] data,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [SIZE_WORD-1:0] load_data,
  output logic [SIZE_WORD-1:0] access_count
);

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  resp_state_t          state_reg, state_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [SIZE_WORD-1:0] addr_reg, wdata_reg, access_count_reg;
  resp_op_t             op_reg;
  logic                 rd_valid_reg, rd_valid_next;
  logic                 proto_err_reg;
  logic                 capture, proto_err;
  logic                 single_req, both_req, addr_oor;
  logic                 cpu_we, rd_en, drive_en;
  logic [SIZE_WORD-1:0] rd_data;

  assign single_req = bus.readM ^ bus.writeM;
  assign both_req   = bus.readM & bus.writeM;
  // Any set bit above the array index makes the captured address out of range.
  assign addr_oor   = (addr_reg >> ADDR_BITS) != '0;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rd_valid_next = rd_valid_reg;
    capture       = 1'b0;
    proto_err     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (both_req) begin
          proto_err     = 1'b1;
          rd_valid_next = 1'b0;
          state_next    = ST_RELEASE;
        end else if (single_req) begin
          capture    = 1'b1;
          cnt_next   = LAT_INIT;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_DONE: begin
        // Only a completed read may drive the bus during RELEASE.
        rd_valid_next = (op_reg == OP_READ);
        state_next    = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.readM && !bus.writeM) begin
          rd_valid_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rd_valid_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rd_valid_reg  <= rd_valid_next;
      proto_err_reg <= proto_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg         <= '0;
      wdata_reg        <= '0;
      op_reg           <= OP_READ;
      access_count_reg <= '0;
    end else begin
      if (capture) begin
        addr_reg <= bus.address;
        op_reg   <= bus.writeM ? OP_WRITE : OP_READ;
        if (bus.writeM) begin
          wdata_reg <= data;
        end
      end
      if (state_reg == ST_DONE) begin
        access_count_reg <= access_count_reg + SIZE_WORD'(1);
      end
    end
  end

  assign cpu_we = (state_reg == ST_DONE) && (op_reg == OP_WRITE) && !addr_oor;
  assign rd_en  = (state_reg == ST_DONE) && (op_reg == OP_READ);

  mem_responder_mem_array #(
    .WIDTH     (SIZE_WORD),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk        (clk),
    .cpu_we     (cpu_we),
    .cpu_addr   (addr_reg[ADDR_BITS-1:0]),
    .cpu_wdata  (wdata_reg),
    .load_we    (load_en),
    .load_addr  (load_addr),
    .load_wdata (load_data),
    .rd_en      (rd_en),
    .rd_addr    (addr_reg[ADDR_BITS-1:0]),
    .rd_data    (rd_data)
  );

  assign bus.ready_m  = (state_reg == ST_DONE);
  assign bus.err_m    = proto_err_reg | ((state_reg == ST_DONE) && addr_oor);
  assign access_count = access_count_reg;

  // Drive enable depends on the live readM so the bus floats as soon as the
  // CPU drops the request; an out-of-range read returns zero.
  assign drive_en = (state_reg == ST_RELEASE) && rd_valid_reg && bus.readM;
  assign data     = drive_en ? (addr_oor ? '0 : rd_data) : 'z;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int SW  = 16;
  localparam int AB  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  mem_responder_if #(.SIZE_WORD(SW)) bus ();
  wire  [SW-1:0] data;
  logic          tb_drv_en;
  logic [SW-1:0] tb_drv;
  logic          load_en;
  logic [AB-1:0] load_addr;
  logic [SW-1:0] load_data;
  logic [SW-1:0] access_count;
  assign data = tb_drv_en ? tb_drv : 'z;
  wire bus_is_z = (data === 16'hzzzz);

  mem_responder #(.SIZE_WORD(SW), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .data(data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .access_count(access_count)
  );

  // narrow instance: LATENCY=1 and a counter that wraps quickly
  mem_responder_if #(.SIZE_WORD(4)) bus2 ();
  wire  [3:0] data2;
  logic       load2_en;
  logic [2:0] load2_addr;
  logic [3:0] load2_data;
  logic [3:0] count2;
  wire bus2_is_z = (data2 === 4'hz);

  mem_responder #(.SIZE_WORD(4), .ADDR_BITS(3), .LATENCY(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .data(data2),
    .load_en(load2_en), .load_addr(load2_addr), .load_data(load2_data),
    .access_count(count2)
  );

  // reference model
  logic [SW-1:0] ref_mem [2**AB];
  logic [SW-1:0] ref_count;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int idx, input logic [SW-1:0] v);
    load_en = 1'b1; load_addr = AB'(idx); load_data = v;
    step();
    load_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // One CPU access: request, wait for ready, check results, hold, drop.
  task automatic access(input bit is_write, input logic [SW-1:0] a, input logic [SW-1:0] wd,
                        input int hold, input bit mid_load, input bit collide, input bit drop_early);
    bit            oor;
    int            cyc;
    int            idx;
    logic [SW-1:0] exp_rd;
    logic [SW-1:0] v;
    oor = (int'(a) >= (1 << AB));
    idx = int'(a) % (1 << AB);
    bus.address = a;
    if (is_write) begin
      bus.writeM = 1'b1; tb_drv = wd; tb_drv_en = 1'b1;
    end else begin
      bus.readM = 1'b1;
    end
    step();                                  // capture edge
    cyc = 1;
    if (drop_early) begin
      bus.readM = 1'b0; bus.writeM = 1'b0; tb_drv_en = 1'b0;
    end
    if (mid_load && !oor && !is_write) begin // load lands before the read completes
      v = 16'($urandom);
      load_en = 1'b1; load_addr = AB'(idx); load_data = v;
      step(); cyc++;
      load_en = 1'b0;
      ref_mem[idx] = v;
    end
    while (bus.ready_m !== 1'b1 && cyc <= 20) begin
      step(); cyc++;
    end
    check("ready_latency", 32'(cyc), 32'(LAT + 1));
    check("err_with_ready", 32'(bus.err_m), 32'(oor));
    exp_rd = oor ? '0 : ref_mem[idx];
    if (collide && is_write && !oor) begin   // load on the CPU write edge
      load_en = 1'b1; load_addr = AB'(idx); load_data = ~wd;
    end
    if (is_write && !oor) ref_mem[idx] = wd;
    step();
    load_en = 1'b0;
    ref_count = ref_count + 16'd1;
    check("ready_single_pulse", 32'(bus.ready_m), 32'd0);
    check("access_count", 32'(access_count), 32'(ref_count));
    if (!is_write && !drop_early) begin
      check("read_data", 32'(data), 32'(exp_rd));
    end else begin
      tb_drv_en = 1'b0; #1;
      check("bus_z_no_read", 32'(bus_is_z), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      check("no_second_access", 32'({bus.ready_m, bus.err_m}), 32'd0);
    end
    if (!is_write && !drop_early) check("read_data_held", 32'(data), 32'(exp_rd));
    bus.readM = 1'b0; bus.writeM = 1'b0; tb_drv_en = 1'b0; #1;
    check("bus_z_after_drop", 32'(bus_is_z), 32'd1);
    step();
  endtask

  logic [SW-1:0] r_addr, r_wd;
  bit            r_w, r_ml, r_col, r_de;
  int            r_hold;

  initial begin
    bus.readM = 1'b0; bus.writeM = 1'b0; bus.address = '0;
    tb_drv_en = 1'b0; tb_drv = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus2.readM = 1'b0; bus2.writeM = 1'b0; bus2.address = '0;
    load2_en = 1'b0; load2_addr = '0; load2_data = '0;
    ref_count = '0;

    // reset state
    #2;
    check("rst_ready", 32'(bus.ready_m), 32'd0);
    check("rst_err", 32'(bus.err_m), 32'd0);
    check("rst_count", 32'(access_count), 32'd0);
    check("rst_bus_z", 32'(bus_is_z), 32'd1);
    step(); step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < (1 << AB); i++) do_load(i, 16'($urandom));

    // directed: load then read
    do_load(5, 16'h1234);
    access(1'b0, 16'd5, '0, 3, 1'b0, 1'b0, 1'b0);
    // write held long, then read back
    access(1'b1, 16'd9, 16'hBEEF, 6, 1'b0, 1'b0, 1'b0);
    access(1'b0, 16'd9, '0, 1, 1'b0, 1'b0, 1'b0);

    // both requests in IDLE: protocol error
    bus.readM = 1'b1; bus.writeM = 1'b1; bus.address = 16'd5;
    tb_drv = 16'h5A5A; tb_drv_en = 1'b1;
    step();
    check("proto_err_pulse", 32'(bus.err_m), 32'd1);
    check("proto_no_ready", 32'(bus.ready_m), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("proto_err_once", 32'({bus.ready_m, bus.err_m}), 32'd0);
    end
    bus.readM = 1'b0; bus.writeM = 1'b0; tb_drv_en = 1'b0; #1;
    check("proto_bus_z", 32'(bus_is_z), 32'd1);
    step();
    check("proto_count", 32'(access_count), 32'(ref_count));
    access(1'b0, 16'd5, '0, 0, 1'b0, 1'b0, 1'b0);

    // out-of-range read and write
    access(1'b0, 16'h0100, '0, 1, 1'b0, 1'b0, 1'b0);
    access(1'b1, 16'h0100, 16'hAAAA, 1, 1'b0, 1'b0, 1'b0);
    access(1'b0, 16'd0, '0, 0, 1'b0, 1'b0, 1'b0);

    // request dropped during WAIT still completes; load visibility; collision
    access(1'b1, 16'd20, 16'h0F0F, 0, 1'b0, 1'b0, 1'b1);
    access(1'b0, 16'd20, '0, 0, 1'b0, 1'b0, 1'b0);
    access(1'b0, 16'd33, '0, 0, 1'b1, 1'b0, 1'b0);
    access(1'b1, 16'd44, 16'h4444, 0, 1'b0, 1'b1, 1'b0);
    access(1'b0, 16'd44, '0, 0, 1'b0, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      r_w    = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 7) == 0) ? 16'(256 + $urandom_range(0, 4000))
                                           : 16'($urandom_range(0, 255));
      r_wd   = 16'($urandom);
      r_hold = $urandom_range(0, 3);
      r_ml   = !r_w && ($urandom_range(0, 3) == 0);
      r_col  = r_w && ($urandom_range(0, 3) == 0);
      r_de   = ($urandom_range(0, 5) == 0);
      access(r_w, r_addr, r_wd, r_hold, r_ml, r_col, r_de);
    end

    // reset during WAIT of a write
    do_load(3, 16'h0001);
    bus.address = 16'd3; bus.writeM = 1'b1; tb_drv = 16'h7777; tb_drv_en = 1'b1;
    step();
    reset_n = 1'b0; bus.writeM = 1'b0; tb_drv_en = 1'b0; #1;
    check("rstmid_ready", 32'(bus.ready_m), 32'd0);
    check("rstmid_bus_z", 32'(bus_is_z), 32'd1);
    check("rstmid_count", 32'(access_count), 32'd0);
    step();
    check("rstmid_ready2", 32'(bus.ready_m), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid_no_ready", 32'(bus.ready_m), 32'd0);
    end
    ref_count = '0;
    access(1'b0, 16'd3, '0, 0, 1'b0, 1'b0, 1'b0);

    // narrow instance: LATENCY=1 and count wrap
    load2_en = 1'b1; load2_addr = 3'd2; load2_data = 4'hA;
    step();
    load2_en = 1'b0;
    bus2.address = 4'd2;
    for (int i = 1; i <= 18; i++) begin
      int c2;
      bus2.readM = 1'b1;
      step();
      c2 = 1;
      while (bus2.ready_m !== 1'b1 && c2 <= 20) begin
        step(); c2++;
      end
      check("lat1_latency", 32'(c2), 32'd2);
      step();
      check("lat1_read_data", 32'(data2), 32'hA);
      check("wrap_count", 32'(count2), 32'(i % 16));
      bus2.readM = 1'b0; #1;
      check("lat1_bus_z", 32'(bus2_is_z), 32'd1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
